accum_sched: RTL and testbench

- Two-requester scheduler and sequencer for the dual-input accumulator datapath (32-bit, in/in2 operands, active-high clear).
- Grants whole bursts round-robin and streams operand beats into the datapath.
- Drains the datapath pipeline, then captures the accumulated result and returns it with requester id and beat count.
- Clears and flushes the datapath before the next burst.

---
 rtl/accum_pkg.sv | 17 +
 rtl/rr_arb2.sv | 28 ++
 rtl/accum_sched.sv | 164 ++++++++++++++++
 tb/tb_accum_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator scheduler.
// Imported by the arbiter and the scheduler top.
package accum_pkg;

    localparam int DATA_W        = 32;
    localparam int PIPE_LAT_DEF  = 6;
    localparam int FLUSH_CYC_DEF = 4;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester
// preferred on a tie and moves past the owner on each advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_adv,
    input  logic       i_adv_id,
    output logic       o_gnt_id,
    output logic       o_any
);

    logic r_ptr;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_adv) begin
            r_ptr <= ~i_adv_id;
        end
    end

    always_comb begin
        o_any    = |i_valid;
        o_gnt_id = (&i_valid) ? r_ptr : i_valid[1];
    end

endmodule

// File: rtl/accum_sched.sv
// Burst scheduler for the dual-input accumulator: grants, streams
// beats, drains the pipe, returns the result, then flushes.
module accum_sched
    import accum_pkg::*;
#(
    parameter int PIPE_LAT  = PIPE_LAT_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int MAX_BEATS = 1024,
    parameter int CW        = 11
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              acc_clr,
    output logic [DATA_W-1:0] acc_in,
    output logic [DATA_W-1:0] acc_in2,
    input  logic [DATA_W-1:0] acc_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    output logic [CW-1:0]     res_beats,
    output logic              res_forced
);

    localparam int TMAX = (PIPE_LAT > FLUSH_CYC) ? PIPE_LAT : FLUSH_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t            r_state, w_nstate;
    logic [TW-1:0]     r_tmr, w_ntmr;
    logic              r_gnt, w_ngnt;
    logic [CW-1:0]     r_cnt;
    logic              r_forced;
    logic              r_rdy0, r_rdy1, r_clr;
    logic [DATA_W-1:0] r_in, r_in2;
    logic              r_rv, r_rid, r_rforced;
    logic [DATA_W-1:0] r_rdata;
    logic [CW-1:0]     r_rbeats;

    logic              w_gnt_id, w_any, w_adv, w_hs;
    logic              w_acc, w_last, w_max;
    logic [DATA_W-1:0] w_a, w_b;
    logic [CW-1:0]     w_cnt_inc;

    assign w_acc     = r_gnt ? (req1_valid & r_rdy1) : (req0_valid & r_rdy0);
    assign w_last    = r_gnt ? req1_last : req0_last;
    assign w_a       = r_gnt ? req1_a : req0_a;
    assign w_b       = r_gnt ? req1_b : req0_b;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_max     = (w_cnt_inc == CW'(MAX_BEATS));
    assign w_hs      = r_rv & res_ready;
    assign w_adv     = (r_state == S_HOLD) & w_hs;
    assign w_ngnt    = (r_state == S_IDLE) ? w_gnt_id : r_gnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .i_rst_n  (areset_n),
        .i_valid  ({req1_valid, req0_valid}),
        .i_adv    (w_adv),
        .i_adv_id (r_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    always_comb begin
        w_nstate = r_state;
        w_ntmr   = r_tmr;
        unique case (r_state)
            S_FLUSH: begin
                if (r_tmr <= TW'(1)) w_nstate = S_IDLE;
                else                 w_ntmr   = r_tmr - 1'b1;
            end
            S_IDLE: begin
                if (w_any) w_nstate = S_RUN;
            end
            S_RUN: begin
                if (w_acc && (w_last || w_max)) begin
                    w_nstate = S_DRAIN;
                    w_ntmr   = TW'(PIPE_LAT);
                end
            end
            S_DRAIN: begin
                if (r_tmr <= TW'(1)) w_nstate = S_HOLD;
                else                 w_ntmr   = r_tmr - 1'b1;
            end
            S_HOLD: begin
                if (w_hs) begin
                    w_nstate = S_FLUSH;
                    w_ntmr   = TW'(FLUSH_CYC);
                end
            end
            default: begin
                w_nstate = S_FLUSH;
                w_ntmr   = TW'(FLUSH_CYC);
            end
        endcase
    end

    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            r_state   <= S_FLUSH;
            r_tmr     <= TW'(FLUSH_CYC);
            r_gnt     <= 1'b0;
            r_cnt     <= '0;
            r_forced  <= 1'b0;
            r_rdy0    <= 1'b0;
            r_rdy1    <= 1'b0;
            r_clr     <= 1'b1;
            r_in      <= '0;
            r_in2     <= '0;
            r_rv      <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= 1'b0;
            r_rbeats  <= '0;
            r_rforced <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_tmr   <= w_ntmr;
            r_gnt   <= w_ngnt;
            r_clr   <= (w_nstate == S_FLUSH);
            r_rdy0  <= (w_nstate == S_RUN) & ~w_ngnt;
            r_rdy1  <= (w_nstate == S_RUN) & w_ngnt;
            r_in    <= w_acc ? w_a : '0;
            r_in2   <= w_acc ? w_b : '0;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_acc) begin
                r_cnt    <= w_cnt_inc;
                r_forced <= w_max & ~w_last;
            end
            if (r_state == S_DRAIN && w_nstate == S_HOLD) begin
                r_rv      <= 1'b1;
                r_rdata   <= acc_result;
                r_rid     <= r_gnt;
                r_rbeats  <= r_cnt;
                r_rforced <= r_forced;
            end else if (w_adv) begin
                r_rv <= 1'b0;
            end
        end
    end

    assign req0_ready = r_rdy0;
    assign req1_ready = r_rdy1;
    assign acc_clr    = r_clr;
    assign acc_in     = r_in;
    assign acc_in2    = r_in2;
    assign res_valid  = r_rv;
    assign res_data   = r_rdata;
    assign res_id     = r_rid;
    assign res_beats  = r_rbeats;
    assign res_forced = r_rforced;

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched with a small accumulator model
// standing in for the datapath.
module tb_accum_sched;

    localparam int PL = 6;
    localparam int FC = 4;
    localparam int MB = 4;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_last = 1'b0, req1_last = 1'b0;
    logic          req0_ready, req1_ready;
    logic          acc_clr;
    logic [31:0]   acc_in, acc_in2, acc_result;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [31:0]   res_data;
    logic          res_id;
    logic [CW-1:0] res_beats;
    logic          res_forced;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] m_d1, m_d2, m_d3, m_acc;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: 3-deep delay line feeding an accumulator.
    always @(posedge clk) begin
        if (acc_clr) begin
            m_d1  <= '0;
            m_d2  <= '0;
            m_d3  <= '0;
            m_acc <= '0;
        end else begin
            m_d1  <= acc_in + acc_in2;
            m_d2  <= m_d1;
            m_d3  <= m_d2;
            m_acc <= m_acc + m_d3;
        end
    end
    assign acc_result = m_acc;

    accum_sched #(
        .PIPE_LAT  (PL),
        .FLUSH_CYC (FC),
        .MAX_BEATS (MB),
        .CW        (CW)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .acc_clr    (acc_clr),
        .acc_in     (acc_in),
        .acc_in2    (acc_in2),
        .acc_result (acc_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_beats  (res_beats),
        .res_forced (res_forced)
    );

    task automatic set_req(input bit id, input logic v,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic l);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_last = l;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_last = l;
        end
    endtask

    // Beats a0, a0+1, ... with operand b0; last on the final beat.
    task automatic drive(input bit id, input int n,
                         input logic [31:0] a0, input logic [31:0] b0);
        int i = 0;
        int g = 0;
        while (i < n && g < 300) begin
            @(negedge clk);
            g++;
            set_req(id, 1'b1, a0 + 32'(i), b0, i == n - 1);
            if (id ? req1_ready : req0_ready) i++;
        end
        @(negedge clk);
        set_req(id, 1'b0, '0, '0, 1'b0);
        total++;
        if (i != n) begin
            bad++;
            $display("FAIL drive_timeout id=%0d: beats=%0d want %0d",
                     id, i, n);
        end
    endtask

    task automatic wait_res();
        int g = 0;
        while (!res_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 areset_n = 1'b1;
        total++;
        if ({acc_clr, req0_ready, req1_ready, res_valid, res_id,
             res_forced} !== 6'b100000 || res_data !== 32'd0 ||
            res_beats !== 11'd0 || acc_in !== 32'd0 ||
            acc_in2 !== 32'd0) begin
            bad++;
            $display("FAIL reset_vals: clr=%b rdy=%b%b rv=%b data=%0h",
                     acc_clr, req0_ready, req1_ready, res_valid, res_data);
        end
        for (int i = 0; i < FC; i++) begin
            @(negedge clk);
            total++;
            if ({acc_clr, req0_ready, req1_ready, res_valid} !== 4'b1000) begin
                bad++;
                $display("FAIL reset_flush[%0d]: got %b want 1000", i,
                         {acc_clr, req0_ready, req1_ready, res_valid});
            end
        end
        @(negedge clk);
        total++;
        if (acc_clr !== 1'b0) begin
            bad++;
            $display("FAIL reset_flush_end: acc_clr=%b want 0", acc_clr);
        end
    endtask

    task automatic test_single();
        int t0, t1;
        res_ready = 1'b1;
        drive(1'b0, 3, 32'd1, 32'd0);
        total++;
        if (acc_in !== 32'd3 || acc_in2 !== 32'd0) begin
            bad++;
            $display("FAIL single_beat3: acc_in=%0d in2=%0d want 3 0",
                     acc_in, acc_in2);
        end
        t0 = cyc;
        wait_res();
        t1 = cyc;
        total++;
        if (t1 - t0 != PL) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d", t1 - t0, PL);
        end
        total++;
        if ({res_valid, res_id, res_forced} !== 3'b100 ||
            res_beats !== 11'd3 || res_data !== 32'd6) begin
            bad++;
            $display("FAIL single_res: v=%b id=%b n=%0d f=%b d=%0d want 1 0 3 0 6",
                     res_valid, res_id, res_beats, res_forced, res_data);
        end
        total++;
        if (res_data !== m_acc) begin
            bad++;
            $display("FAIL single_model: got %0d want %0d", res_data, m_acc);
        end
        @(negedge clk);
        total++;
        if ({res_valid, acc_clr} !== 2'b01) begin
            bad++;
            $display("FAIL single_release: rv,clr=%b want 01",
                     {res_valid, acc_clr});
        end
    endtask

    task automatic test_contention();
        bit done = 1'b0;
        int viol = 0;
        areset_n = 1'b0;
        set_req(1'b0, 1'b1, 32'd1, 32'd5, 1'b0);
        set_req(1'b1, 1'b1, 32'd1000, 32'd7, 1'b0);
        @(posedge clk);
        #1 areset_n = 1'b1;
        fork
            for (int k = 0; k < 3; k++) drive(1'b0, 2, 32'(1 + k * 10), 32'd5);
            for (int k = 0; k < 3; k++) drive(1'b1, 2, 32'(1000 + k * 10), 32'd7);
            begin
                for (int j = 0; j < 6; j++) begin
                    logic        eid;
                    logic [31:0] ea;
                    logic [31:0] es;
                    eid = 1'(j % 2);
                    ea  = eid ? 32'(1000 + (j / 2) * 10) : 32'(1 + (j / 2) * 10);
                    es  = 2 * ea + 1 + (eid ? 32'd14 : 32'd10);
                    wait_res();
                    total++;
                    if ({res_valid, res_id, res_forced} !== {1'b1, eid, 1'b0} ||
                        res_beats !== 11'd2 || res_data !== es) begin
                        bad++;
                        $display("FAIL cont_res[%0d]: v=%b id=%b n=%0d d=%0d want id=%b n=2 d=%0d",
                                 j, res_valid, res_id, res_beats, res_data, eid, es);
                    end
                    @(negedge clk);
                end
                done = 1'b1;
            end
            while (!done) begin
                @(negedge clk);
                if (req0_ready && req1_ready) viol++;
            end
        join
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL cont_excl: both-ready cycles=%0d want 0", viol);
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        set_req(1'b1, 1'b1, 32'd40, 32'd2, 1'b1);
        drive(1'b0, 2, 32'd5, 32'd1);
        wait_res();
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({res_valid, req0_ready, req1_ready, res_id, res_forced}
                    !== 5'b10000 || res_beats !== 11'd2 ||
                res_data !== 32'd13) begin
                bad++;
                $display("FAIL bp_hold[%0d]: v=%b rdy=%b%b id=%b n=%0d d=%0d want d=13 n=2",
                         i, res_valid, req0_ready, req1_ready, res_id,
                         res_beats, res_data);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({res_valid, acc_clr} !== 2'b01) begin
            bad++;
            $display("FAIL bp_release: rv,clr=%b want 01", {res_valid, acc_clr});
        end
        for (int i = 0; i < FC - 1; i++) begin
            @(negedge clk);
            total++;
            if (acc_clr !== 1'b1) begin
                bad++;
                $display("FAIL bp_flush[%0d]: acc_clr=%b want 1", i, acc_clr);
            end
        end
        @(negedge clk);
        total++;
        if (acc_clr !== 1'b0) begin
            bad++;
            $display("FAIL bp_flush_end: acc_clr=%b want 0", acc_clr);
        end
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_waiter_grant: rdy=%b%b want 01",
                     req0_ready, req1_ready);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        wait_res();
        total++;
        if ({res_valid, res_id, res_forced} !== 3'b110 ||
            res_beats !== 11'd1 || res_data !== 32'd42) begin
            bad++;
            $display("FAIL bp_waiter_res: id=%b n=%0d d=%0d want 1 1 42",
                     res_id, res_beats, res_data);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        fork
            drive(1'b1, 6, 32'd1, 32'd0);
            begin
                wait_res();
                total++;
                if ({res_valid, res_id, res_forced} !== 3'b111 ||
                    res_beats !== 11'd4 || res_data !== 32'd10) begin
                    bad++;
                    $display("FAIL ovf_first: id=%b n=%0d f=%b d=%0d want 1 4 1 10",
                             res_id, res_beats, res_forced, res_data);
                end
                @(negedge clk);
                wait_res();
                total++;
                if ({res_valid, res_id, res_forced} !== 3'b110 ||
                    res_beats !== 11'd2 || res_data !== 32'd11) begin
                    bad++;
                    $display("FAIL ovf_second: id=%b n=%0d f=%b d=%0d want 1 2 0 11",
                             res_id, res_beats, res_forced, res_data);
                end
                @(negedge clk);
            end
        join
    endtask

    task automatic test_midreset();
        int i = 0;
        int g = 0;
        int rv_seen = 0;
        res_ready = 1'b1;
        while (i < 2 && g < 100) begin
            @(negedge clk);
            g++;
            set_req(1'b0, 1'b1, 32'(100 + i), 32'd0, 1'b0);
            if (req0_ready) i++;
        end
        @(negedge clk);
        areset_n = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1 areset_n = 1'b1;
        total++;
        if (i != 2 || {acc_clr, req0_ready, res_valid} !== 3'b100 ||
            res_data !== 32'd0 || res_beats !== 11'd0) begin
            bad++;
            $display("FAIL mid_reset: beats=%0d clr=%b rdy=%b rv=%b d=%0d want 2 1 0 0 0",
                     i, acc_clr, req0_ready, res_valid, res_data);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (res_valid) rv_seen++;
        end
        total++;
        if (rv_seen != 0) begin
            bad++;
            $display("FAIL mid_no_result: res_valid cycles=%0d want 0", rv_seen);
        end
        drive(1'b0, 2, 32'd7, 32'd0);
        wait_res();
        total++;
        if ({res_valid, res_id, res_forced} !== 3'b100 ||
            res_beats !== 11'd2 || res_data !== 32'd15) begin
            bad++;
            $display("FAIL mid_next: id=%b n=%0d d=%0d want 0 2 15",
                     res_id, res_beats, res_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overflow();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
